// File: rtl/seq_mult.sv
// Sequential shift-add multiplier with valid/ready handshakes on both sides.
// Consumes one multiplier bit per clock: YW BUSY cycles per product, then the
// result is held in DONE until the consumer takes it.
// Optional build macro SEQ_MULT_SIGNED_EN adds an is_signed input for
// two's-complement operands (magnitude multiply, sign fixed up at the end).
module seq_mult #(
  parameter int unsigned XW = 8,
  parameter int unsigned YW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XW-1:0]        x,
  input  logic [YW-1:0]        y,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic                 is_signed,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XW+YW-1:0]     p,
  output logic                 busy
);

  localparam int unsigned PW = XW + YW;
  localparam int unsigned CW = $clog2(YW + 1);
  localparam logic [CW-1:0] CntLast = CW'(YW - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   x_q, x_d;     // multiplicand, shifted left each step
  logic [YW-1:0]   y_q, y_d;     // multiplier, shifted right each step
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   p_q, p_d;
  logic            neg_q, neg_d; // result must be negated when loaded into p

  logic [XW-1:0]   x_mag;
  logic [YW-1:0]   y_mag;
  logic            neg_in;
  logic [PW-1:0]   acc_sum;

  // Operand conditioning: magnitudes and result sign at the accepting edge.
  always_comb begin
    x_mag  = x;
    y_mag  = y;
    neg_in = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
    if (is_signed) begin
      // The most negative value maps to its own bit pattern, which read as
      // unsigned is exactly the required magnitude.
      if (x[XW-1]) x_mag = -x;
      if (y[YW-1]) y_mag = -y;
      neg_in = x[XW-1] ^ y[YW-1];
    end
`endif
  end

  // Partial-product add for the current multiplier bit.
  always_comb begin
    acc_sum = acc_q + (y_q[0] ? x_q : '0);
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    neg_d     = neg_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          x_d     = {{YW{1'b0}}, x_mag};
          y_d     = y_mag;
          acc_d   = '0;
          cnt_d   = '0;
          neg_d   = neg_in;
          state_d = StBusy;
        end
      end
      StBusy: begin
        acc_d = acc_sum;
        x_d   = x_q << 1;
        y_d   = y_q >> 1;
        cnt_d = cnt_q + CW'(1);
        // Last multiplier bit: no early exit on zero operands.
        if (cnt_q == CntLast) begin
          p_d     = neg_q ? -acc_sum : acc_sum;
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; synchronous reset discards any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      neg_q   <= neg_d;
    end
  end

  assign p = p_q;

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult (XW=YW=8). Define SEQ_MULT_SIGNED_EN for
// the signed-operand tests as well.
module tb_seq_mult;

  localparam int XW = 8;
  localparam int YW = 8;
  localparam int PW = XW + YW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] p;
  logic          busy;
`ifdef SEQ_MULT_SIGNED_EN
  logic          is_signed;
`endif

  int errors = 0;
  int checks = 0;
  logic [PW-1:0] last_p;  // value p must hold outside the BUSY->DONE edge

  seq_mult #(.XW(XW), .YW(YW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
`ifdef SEQ_MULT_SIGNED_EN
    .is_signed (is_signed),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference product from plain integer arithmetic.
  function automatic logic [PW-1:0] model(input logic [XW-1:0] a, input logic [YW-1:0] b,
                                           input logic sg);
    int unsigned ua;
    int unsigned ub;
    int sa;
    int sb;
    int prod;
    logic [31:0] r;
    if (sg) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      prod = sa * sb;
      r = prod;
    end else begin
      ua = a;
      ub = b;
      r = ua * ub;
    end
    return r[PW-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with out_ready held high; checks latency, p, busy
  // phase behaviour and return to IDLE.
  task automatic run_op(input logic [XW-1:0] xa, input logic [YW-1:0] ya, input logic sg,
                        input logic [PW-1:0] exp, input string nm);
    int lat;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle_ready: got %b expected 1", nm, in_ready);
    end
    x = xa;
    y = ya;
`ifdef SEQ_MULT_SIGNED_EN
    is_signed = sg;
`endif
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    // Scramble inputs after the accept edge; they must have no effect.
    in_valid = 1'b0;
    x = XW'($urandom);
    y = YW'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
    is_signed = ~sg;
`endif
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || p !== last_p) begin
        errors++;
        $display("FAIL %s_busy_phase: got busy=%b in_ready=%b p=%h expected 1 0 %h",
                 nm, busy, in_ready, p, last_p);
      end
      step();
      lat++;
    end
    checks++;
    if (lat != YW) begin
      errors++;
      $display("FAIL %s_latency: got %0d expected %0d", nm, lat, YW);
    end
    checks++;
    if (p !== exp) begin
      errors++;
      $display("FAIL %s_product: got %h expected %h", nm, p, exp);
    end
    last_p = exp;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== exp) begin
      errors++;
      $display("FAIL %s_return_idle: got in_ready=%b out_valid=%b busy=%b p=%h expected 1 0 0 %h",
               nm, in_ready, out_valid, busy, p, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0;
    y = '0;
`ifdef SEQ_MULT_SIGNED_EN
    is_signed = 1'b0;
`endif
    step();
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== '0) begin
      errors++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b busy=%b p=%h expected 1 0 0 0",
               in_ready, out_valid, busy, p);
    end
    rst = 1'b0;
    last_p = '0;
    step();
  endtask

  task automatic test_basic();
    run_op(8'd13, 8'd11, 1'b0, 16'd143, "basic");
  endtask

  task automatic test_extremes();
    run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, "max_max");
    run_op(8'h00, 8'hA5, 1'b0, 16'h0000, "zero_x");
    run_op(8'hA5, 8'h00, 1'b0, 16'h0000, "zero_y");
    run_op(8'h01, 8'h80, 1'b0, 16'h0080, "msb_y");
  endtask

  task automatic test_backpressure();
    int lat;
    x = 8'd3;
    y = 8'd5;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    checks++;
    if (lat != YW) begin
      errors++;
      $display("FAIL bp_latency: got %0d expected %0d", lat, YW);
    end
    // A new request must be ignored while DONE holds the result.
    in_valid = 1'b1;
    x = 8'd9;
    y = 8'd9;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || p !== 16'd15) begin
        errors++;
        $display("FAIL bp_hold: got out_valid=%b in_ready=%b busy=%b p=%h expected 1 0 1 000f",
                 out_valid, in_ready, busy, p);
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== 16'd15) begin
      errors++;
      $display("FAIL bp_release: got in_ready=%b out_valid=%b busy=%b p=%h expected 1 0 0 000f",
               in_ready, out_valid, busy, p);
    end
    last_p = 16'd15;
  endtask

  task automatic test_reset_mid_op();
    x = 8'd7;
    y = 8'd9;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;  // fourth BUSY edge is the reset edge
    step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== '0) begin
      errors++;
      $display("FAIL rst_mid_state: got in_ready=%b out_valid=%b busy=%b p=%h expected 1 0 0 0",
               in_ready, out_valid, busy, p);
    end
    last_p = '0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_no_output: got out_valid=%b busy=%b expected 0 0",
                 out_valid, busy);
      end
      step();
    end
    run_op(8'd2, 8'd3, 1'b0, 16'd6, "after_rst");
  endtask

  task automatic test_random();
    logic [XW-1:0] a;
    logic [YW-1:0] b;
    for (int i = 0; i < 20; i++) begin
      a = XW'($urandom);
      b = YW'($urandom);
      run_op(a, b, 1'b0, model(a, b, 1'b0), "rand");
    end
  endtask

  // in_valid held high continuously: accepts must be YW+2 cycles apart.
  task automatic test_back_to_back();
    logic [XW-1:0] xs[3];
    logic [YW-1:0] ys[3];
    logic [PW-1:0] q[$];
    logic [PW-1:0] e;
    logic will_accept;
    int cyc;
    int n_acc;
    int n_done;
    int last_done;
    for (int i = 0; i < 3; i++) begin
      xs[i] = XW'($urandom);
      ys[i] = YW'($urandom);
    end
    cyc = 0;
    n_acc = 0;
    n_done = 0;
    last_done = -1;
    x = xs[0];
    y = ys[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (n_done < 3 && cyc < 200) begin
      will_accept = in_ready && in_valid;
      step();
      cyc++;
      if (will_accept) begin
        q.push_back(model(xs[n_acc], ys[n_acc], 1'b0));
        n_acc++;
        if (n_acc < 3) begin
          x = xs[n_acc];
          y = ys[n_acc];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid === 1'b1) begin
        e = (q.size() > 0) ? q.pop_front() : 'x;
        checks++;
        if (p !== e) begin
          errors++;
          $display("FAIL b2b_product: got %h expected %h", p, e);
        end
        if (last_done >= 0) begin
          checks++;
          if (cyc - last_done != YW + 2) begin
            errors++;
            $display("FAIL b2b_interval: got %0d expected %0d", cyc - last_done, YW + 2);
          end
        end
        last_done = cyc;
        last_p = p;
        n_done++;
      end
    end
    checks++;
    if (n_done != 3) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d results expected 3", n_done);
    end
    in_valid = 1'b0;
    step();
  endtask

`ifdef SEQ_MULT_SIGNED_EN
  task automatic test_signed();
    logic [XW-1:0] a;
    logic [YW-1:0] b;
    run_op(8'hFD, 8'd5, 1'b1, 16'hFFF1, "signed_neg");
    run_op(8'h80, 8'h80, 1'b1, 16'h4000, "signed_min");
    run_op(8'hFD, 8'd5, 1'b0, 16'd1265, "signed_off");
    for (int i = 0; i < 10; i++) begin
      a = XW'($urandom);
      b = YW'($urandom);
      run_op(a, b, 1'b1, model(a, b, 1'b1), "signed_rand");
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    test_back_to_back();
`ifdef SEQ_MULT_SIGNED_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
